// File: rtl/funnel_dat_pipe.sv
// Wide-to-narrow data funnel: one N_IN-lane word in, NBW_eff beats of N_OUT lanes out.
// Optional descending beat order is compiled in with `define FUNNEL_DAT_REVERSE_EN.
module funnel_dat_pipe #(
    parameter int LANE_W = 128,
    parameter int N_IN   = 8,
    parameter int N_OUT  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_IN*LANE_W-1:0]    t_0_dat,
    input  logic [7:0]                t_cfg_dat,
    input  logic                      t_valid,
    output logic                      t_ready,
    output logic [N_OUT*LANE_W-1:0]   i_dat,
    output logic                      i_valid,
    input  logic                      i_ready,
    output logic                      i_last,
    output logic [3:0]                i_beat,
    output logic [7:0]                mode
);

    localparam int NB     = N_IN / N_OUT;
    localparam int WORD_W = N_IN * LANE_W;
    localparam int BEAT_W = N_OUT * LANE_W;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [7:0]          mode_q, mode_d;
    logic [3:0]          bc_q, bc_d;
    logic [3:0]          last_q, last_d;

    logic                out_xfer;
    logic                in_xfer;
    logic [3:0]          cfg_last;
    logic [3:0]          beat_sel;

    // last_q holds the index of the final beat, so i_last is a plain equality
    always_comb begin
        cfg_last = 4'(NB - 1);
        if ((t_cfg_dat[3:0] != 4'd0) && ({1'b0, t_cfg_dat[3:0]} <= 5'(NB))) begin
            cfg_last = t_cfg_dat[3:0] - 4'd1;
        end
    end

    assign i_valid  = (state_q == STREAM);
    assign i_last   = i_valid && (bc_q == last_q);
    assign i_beat   = bc_q;
    assign mode     = mode_q;
    assign out_xfer = i_valid && i_ready;
    assign t_ready  = !reset && ((state_q == IDLE) || (out_xfer && i_last));
    assign in_xfer  = t_valid && t_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mode_d  = mode_q;
        bc_d    = bc_q;
        last_d  = last_q;
        // A new word can only land while idle or on the last beat's transfer
        if (in_xfer) begin
            state_d = STREAM;
            word_d  = t_0_dat;
            mode_d  = t_cfg_dat;
            bc_d    = 4'd0;
            last_d  = cfg_last;
        end else if (out_xfer) begin
            if (i_last) begin
                state_d = IDLE;
            end else begin
                bc_d = bc_q + 4'd1;
            end
        end
    end

    always_comb begin
`ifdef FUNNEL_DAT_REVERSE_EN
        beat_sel = mode_q[4] ? (last_q - bc_q) : bc_q;
`else
        beat_sel = bc_q;
`endif
    end

    always_comb begin
        i_dat = '0;
        for (int b = 0; b < NB; b++) begin
            if (beat_sel == 4'(b)) begin
                i_dat = word_q[b*BEAT_W +: BEAT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            mode_q  <= '0;
            bc_q    <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            bc_q    <= bc_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_funnel_dat_pipe.sv
// Bench for funnel_dat_pipe: directed plus randomized traffic against a beat-queue model,
// with a second narrow (N_OUT=1) instance for beat-count and clamping checks.
module tb_funnel_dat_pipe;

    localparam int LANE_W = 128;
    localparam int N_IN   = 8;
    localparam int N_OUT  = 4;
    localparam int NB     = N_IN / N_OUT;
    localparam int WW     = N_IN * LANE_W;
    localparam int BW     = N_OUT * LANE_W;

    logic            clk = 1'b0;
    logic            reset;
    logic [WW-1:0]   t_0_dat;
    logic [7:0]      t_cfg_dat;
    logic            t_valid;
    logic            t_ready;
    logic [BW-1:0]   i_dat;
    logic            i_valid;
    logic            i_ready;
    logic            i_last;
    logic [3:0]      i_beat;
    logic [7:0]      mode;

    logic [63:0]     n_dat;
    logic [7:0]      n_cfg;
    logic            n_tv;
    logic            n_tr;
    logic [7:0]      n_i_dat;
    logic            n_i_valid;
    logic            n_i_ready;
    logic            n_i_last;
    logic [3:0]      n_i_beat;
    logic [7:0]      n_mode;

    funnel_dat_pipe #(.LANE_W(LANE_W), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .reset(reset),
        .t_0_dat(t_0_dat), .t_cfg_dat(t_cfg_dat), .t_valid(t_valid), .t_ready(t_ready),
        .i_dat(i_dat), .i_valid(i_valid), .i_ready(i_ready), .i_last(i_last),
        .i_beat(i_beat), .mode(mode)
    );

    funnel_dat_pipe #(.LANE_W(8), .N_IN(8), .N_OUT(1)) dut_n (
        .clk(clk), .reset(reset),
        .t_0_dat(n_dat), .t_cfg_dat(n_cfg), .t_valid(n_tv), .t_ready(n_tr),
        .i_dat(n_i_dat), .i_valid(n_i_valid), .i_ready(n_i_ready), .i_last(n_i_last),
        .i_beat(n_i_beat), .mode(n_mode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [BW-1:0] dat;
        logic          last;
        logic [3:0]    beat;
        logic [7:0]    mode;
    } beat_t;

    beat_t exp_q[$];
    bit    after_rst = 1'b1;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_beats(input logic [7:0] cfg, input int nb);
        int n;
        n = int'(cfg[3:0]);
        if (n == 0 || n > nb) n = nb;
        return n;
    endfunction

    // Model: an accepted word becomes a list of expected beats
    task automatic push_word(input logic [WW-1:0] w, input logic [7:0] cfg);
        int n;
        bit rev;
        n   = eff_beats(cfg, NB);
        rev = 1'b0;
`ifdef FUNNEL_DAT_REVERSE_EN
        rev = cfg[4];
`endif
        for (int b = 0; b < n; b++) begin
            beat_t e;
            int    src;
            src    = rev ? (n - 1 - b) : b;
            e.dat  = w[src*BW +: BW];
            e.last = (b == n - 1);
            e.beat = 4'(b);
            e.mode = cfg;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input bit rst, input bit tv, input logic [WW-1:0] w,
                        input logic [7:0] cfg, input bit ir);
        bit exp_tr;
        reset     = rst;
        t_valid   = tv;
        t_0_dat   = w;
        t_cfg_dat = cfg;
        i_ready   = ir;
        @(negedge clk);
        exp_tr = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && ir));
        chk("t_ready", BW'(t_ready), BW'(exp_tr));
        chk("i_valid", BW'(i_valid), BW'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("i_dat",  i_dat,         exp_q[0].dat);
            chk("i_last", BW'(i_last),   BW'(exp_q[0].last));
            chk("i_beat", BW'(i_beat),   BW'(exp_q[0].beat));
            chk("mode",   BW'(mode),     BW'(exp_q[0].mode));
        end else if (after_rst) begin
            chk("rst_i_dat",  i_dat,       '0);
            chk("rst_mode",   BW'(mode),   '0);
            chk("rst_i_beat", BW'(i_beat), '0);
            chk("rst_i_last", BW'(i_last), '0);
        end
        if (rst) begin
            exp_q.delete();
            after_rst = 1'b1;
        end else begin
            if (exp_q.size() > 0 && ir) void'(exp_q.pop_front());
            if (tv && exp_tr) begin
                push_word(w, cfg);
                after_rst = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic narrow_run(input logic [7:0] cfg, input int nbeats);
        n_tv  = 1'b1;
        n_cfg = cfg;
        n_dat = 64'h0706_0504_0302_0100;
        @(negedge clk);
        chk("n_t_ready", BW'(n_tr), BW'(1));
        @(posedge clk);
        #1;
        n_tv = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            chk("n_i_valid", BW'(n_i_valid), BW'(1));
            chk("n_i_dat",   BW'(n_i_dat),   BW'(b));
            chk("n_i_beat",  BW'(n_i_beat),  BW'(b));
            chk("n_i_last",  BW'(n_i_last),  BW'(b == nbeats - 1));
            chk("n_mode",    BW'(n_mode),    BW'(cfg));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("n_i_valid_end", BW'(n_i_valid), BW'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        logic [WW-1:0] wk, wa, wb;
        for (int k = 0; k < N_IN; k++) wk[k*LANE_W +: LANE_W] = LANE_W'(k + 1);
        wa = rand_word();
        wb = rand_word();

        reset = 1'b1; t_valid = 1'b0; t_0_dat = '0; t_cfg_dat = '0; i_ready = 1'b1;
        n_tv = 1'b0; n_dat = '0; n_cfg = '0; n_i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset wins over a simultaneous t_valid
        step(1, 1, wa, 8'h00, 1);
        // default in-order beats
        step(0, 1, wk, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        // back-to-back words with t_valid held
        step(0, 1, wa, 8'h00, 1);
        step(0, 1, wb, 8'h00, 1);
        step(0, 1, wb, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        // stall pattern 1,0,0,1
        step(0, 1, wk, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 0);
        step(0, 1, wa, 8'h00, 0);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        // truncation, clamping, upper cfg bits, order select
        step(0, 1, wk, 8'hE1, 1);
        step(0, 1, wa, 8'h0F, 1);
        step(0, 1, wb, 8'h03, 1);
        step(0, 1, wk, 8'h10, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        // reset while beat 0 is valid
        step(0, 1, wa, 8'h02, 1);
        step(1, 1, wb, 8'h02, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 1, wk, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);

        for (int n = 0; n < 400; n++) begin
            step(($urandom % 64) == 0, ($urandom % 4) != 0, rand_word(),
                 8'($urandom), ($urandom % 4) != 0);
        end
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);
        step(0, 0, '0, 8'h00, 1);

        narrow_run(8'h03, 3);
        narrow_run(8'h0F, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
